// File: rtl/wb_burst_slave_mem_if.sv
// rtl/wb_burst_slave_mem_if.sv - Wishbone B4 bus bundle between the master and wb_burst_slave_mem
interface wb_burst_slave_mem_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
);
  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] adr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [SEL_WIDTH-1:0]  sel_i;
  logic [2:0]            cti_i;
  logic [1:0]            bte_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  ack_o;
  logic                  err_o;
  logic [1:0]            state_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, cti_i, bte_i,
    output dat_o, ack_o, err_o, state_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, cti_i, bte_i,
    input  dat_o, ack_o, err_o, state_o
  );
endinterface

// File: rtl/wb_burst_slave_mem.sv
// rtl/wb_burst_slave_mem.sv - Wishbone B4 registered-feedback burst slave memory
// Optional beat/error statistics outputs enabled by WB_BURST_STATS_EN.
module wb_burst_slave_mem #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8,
  parameter int DEPTH      = 24
) (
  input  logic clk_i,
  input  logic rst_i,
  wb_burst_slave_mem_if.slave bus
`ifdef WB_BURST_STATS_EN
  ,
  output logic [7:0] beat_cnt_o,
  output logic [7:0] err_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_CLASSIC = 2'b01,
    S_BURST   = 2'b10,
    S_ERR     = 2'b11
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  ack_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  req_err;
  logic                  is_burst_cti;
  logic                  beat_done;
  logic                  wr_en;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  // Linear uses an all-ones mask so the same expression covers every BTE.
  always_comb begin
    wrap_mask = '1;
    case (bus.bte_i)
      2'b01:   wrap_mask = ADDR_WIDTH'(3);
      2'b10:   wrap_mask = ADDR_WIDTH'(7);
      2'b11:   wrap_mask = ADDR_WIDTH'(15);
      default: wrap_mask = '1;
    endcase
    if (bus.cti_i == 3'b001)
      next_addr = cur_addr;
    else
      next_addr = (cur_addr & ~wrap_mask) | ((cur_addr + ADDR_WIDTH'(1)) & wrap_mask);
  end

  assign req_err      = !in_range(bus.adr_i) || (bus.cti_i inside {[3'b011:3'b110]});
  assign is_burst_cti = (bus.cti_i == 3'b001) || (bus.cti_i == 3'b010);
  assign beat_done    = bus.cyc_i && bus.stb_i && ack_q;
  assign wr_en        = beat_done && bus.we_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < SEL_WIDTH; k++)
        if (bus.sel_i[k]) mem[cur_addr][8*k +: 8] <= bus.dat_i[8*k +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      cur_addr <= '0;
      dat_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (!bus.cyc_i) begin
      state <= S_IDLE;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.stb_i) begin
            if (req_err) begin
              err_q <= 1'b1;
              state <= S_ERR;
            end else begin
              cur_addr <= bus.adr_i;
              dat_q    <= mem[bus.adr_i];
              ack_q    <= 1'b1;
              state    <= is_burst_cti ? S_BURST : S_CLASSIC;
            end
          end
        end
        S_CLASSIC: begin
          ack_q <= 1'b0;
          state <= S_IDLE;
        end
        S_BURST: begin
          if (!bus.stb_i) begin
            ack_q <= 1'b0;
          end else if (!ack_q) begin
            // Resuming after a master wait state: re-present the held address.
            ack_q <= 1'b1;
            dat_q <= mem[cur_addr];
          end else if (bus.cti_i == 3'b111) begin
            ack_q <= 1'b0;
            state <= S_IDLE;
          end else if (!in_range(next_addr)) begin
            ack_q <= 1'b0;
            err_q <= 1'b1;
            state <= S_ERR;
          end else begin
            cur_addr <= next_addr;
            dat_q    <= mem[next_addr];
          end
        end
        default: begin
          err_q <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dat_o   = dat_q;
  assign bus.ack_o   = ack_q;
  assign bus.err_o   = err_q;
  assign bus.state_o = state;

`ifdef WB_BURST_STATS_EN
  logic [7:0] run_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_cnt    <= '0;
      beat_cnt_o <= '0;
      err_cnt_o  <= '0;
    end else begin
      if (err_q && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
      if (state == S_IDLE && bus.cyc_i && bus.stb_i && !req_err && is_burst_cti) begin
        run_cnt <= '0;
      end else if (state == S_BURST && beat_done) begin
        run_cnt <= run_cnt + 8'd1;
        if (bus.cti_i == 3'b111) beat_cnt_o <= run_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_burst_slave_mem.sv
// tb/tb_wb_burst_slave_mem.sv - directed vector bench for wb_burst_slave_mem
module tb_wb_burst_slave_mem;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  wb_burst_slave_mem_if bus ();

`ifdef WB_BURST_STATS_EN
  logic [7:0] beat_cnt;
  logic [7:0] err_cnt;
  wb_burst_slave_mem dut (.clk_i(clk), .rst_i(rst), .bus(bus), .beat_cnt_o(beat_cnt), .err_cnt_o(err_cnt));
`else
  wb_burst_slave_mem dut (.clk_i(clk), .rst_i(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] bw[8];
  logic [31:0] br[8];
  logic        back[8];
  logic        berr[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic classic(input vec_t v, input string nm);
    int lat;
    @(posedge clk); #1;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = v.we; bus.adr_i = v.adr;
    bus.dat_i = v.dat; bus.sel_i = v.sel; bus.cti_i = v.cti; bus.bte_i = 2'b00;
    lat = 0;
    while (!(bus.ack_o || bus.err_o) && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd1);
    chk({nm, "_err"}, {31'd0, bus.err_o}, {31'd0, v.exp_err});
    chk({nm, "_ack"}, {31'd0, bus.ack_o}, {31'd0, !v.exp_err});
    if (!v.we && !v.exp_err) chk({nm, "_data"}, bus.dat_o, v.exp_dat);
    @(posedge clk); #1;
    chk({nm, "_pulse"}, {30'd0, bus.ack_o, bus.err_o}, 32'd0);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.cti_i = 3'b000;
  endtask

  // Runs an n-beat burst; first beat must see one wait state, later beats none.
  task automatic burst(input logic we, input logic [4:0] adr0, input logic [1:0] bte,
                       input logic [2:0] cti_mid, input int n, input string nm);
    logic [4:0] a;
    logic [4:0] m;
    int         waits;
    a = adr0;
    m = (bte == 2'b01) ? 5'd3 : (bte == 2'b10) ? 5'd7 : (bte == 2'b11) ? 5'd15 : 5'h1F;
    for (int i = 0; i < 8; i++) begin back[i] = 1'b0; berr[i] = 1'b0; br[i] = '0; end
    @(posedge clk); #1;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we; bus.sel_i = 4'hF; bus.bte_i = bte;
    for (int i = 0; i < n; i++) begin
      bus.adr_i = a;
      bus.dat_i = bw[i];
      bus.cti_i = (i == n - 1) ? 3'b111 : cti_mid;
      waits = 0;
      while (!(bus.ack_o || bus.err_o) && waits < 8) begin
        @(posedge clk); #1;
        waits++;
      end
      chk($sformatf("%s_wait%0d", nm, i), 32'(waits), (i == 0) ? 32'd1 : 32'd0);
      back[i] = bus.ack_o;
      berr[i] = bus.err_o;
      br[i]   = bus.dat_o;
      if (bus.err_o || !bus.ack_o) break;
      if (cti_mid != 3'b001) a = (a & ~m) | ((a + 5'd1) & m);
      @(posedge clk); #1;
    end
    if (berr[n-1]) begin
      @(posedge clk); #1;
    end
    chk({nm, "_end"}, {29'd0, bus.state_o, bus.ack_o}, 32'd0);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.cti_i = 3'b000;
  endtask

  initial begin
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.adr_i = '0;
    bus.dat_i = '0; bus.sel_i = '0; bus.cti_i = '0; bus.bte_i = '0;

    vecs[0]  = '{1'b1, 5'd0,  32'h0000_1111, 4'hF, 3'b000, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         4'hF, 3'b000, 1'b0, 32'h0000_1111};
    vecs[2]  = '{1'b1, 5'd1,  32'h1111_1111, 4'hF, 3'b111, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 5'd1,  32'hAABB_CCDD, 4'h2, 3'b000, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 5'd1,  32'h0,         4'hF, 3'b000, 1'b0, 32'h1111_CC11};
    vecs[5]  = '{1'b1, 5'd20, 32'h1234_5678, 4'hF, 3'b000, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 5'd25, 32'hDEAD_BEEF, 4'hF, 3'b000, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 5'd20, 32'h0,         4'hF, 3'b000, 1'b0, 32'h1234_5678};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         4'hF, 3'b011, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 4'hF, 3'b110, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,         4'hF, 3'b000, 1'b0, 32'h0000_1111};
    vecs[11] = '{1'b0, 5'd23, 32'h0,         4'hF, 3'b000, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 5'd24, 32'h0,         4'hF, 3'b000, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 5'd10, 32'h0,         4'hF, 3'b000, 1'b0, 32'h0000_0003};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.dat_o[29:0], bus.ack_o, bus.err_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset", {28'd0, bus.state_o, bus.ack_o, bus.err_o}, 32'd0);

    for (int i = 0; i < 13; i++) classic(vecs[i], $sformatf("vec%0d", i));

    bw[0] = 32'hA0; bw[1] = 32'hA1; bw[2] = 32'hA2; bw[3] = 32'hA3;
    burst(1'b1, 5'd4, 2'b00, 3'b010, 4, "lin_wr");
`ifdef WB_BURST_STATS_EN
    chk("beat_cnt", {24'd0, beat_cnt}, 32'd4);
`endif
    burst(1'b0, 5'd4, 2'b00, 3'b010, 4, "lin_rd");
    for (int i = 0; i < 4; i++) chk($sformatf("lin_rd_d%0d", i), br[i], 32'hA0 + 32'(i));

    bw[0] = 32'h40; bw[1] = 32'h41; bw[2] = 32'h42; bw[3] = 32'h43;
    burst(1'b1, 5'd4, 2'b00, 3'b010, 4, "pre_wr");
    burst(1'b0, 5'd6, 2'b01, 3'b010, 4, "wrap4");
    chk("wrap4_d0", br[0], 32'h42);
    chk("wrap4_d1", br[1], 32'h43);
    chk("wrap4_d2", br[2], 32'h40);
    chk("wrap4_d3", br[3], 32'h41);

    bw[0] = 32'h1; bw[1] = 32'h2; bw[2] = 32'h3;
    burst(1'b1, 5'd10, 2'b00, 3'b001, 3, "const_wr");
    classic(vecs[13], "const_rd");

    burst(1'b0, 5'd22, 2'b00, 3'b010, 3, "oor");
    chk("oor_acks", {29'd0, back[0], back[1], back[2]}, 32'b110);
    chk("oor_err", {29'd0, berr[0], berr[1], berr[2]}, 32'b001);

    // Master wait state mid-burst at 0x40.. region
    @(posedge clk); #1;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = 5'd4;
    bus.cti_i = 3'b010; bus.bte_i = 2'b00;
    @(posedge clk); #1;
    chk("ws_beat0", {bus.dat_o[30:0], bus.ack_o}, {31'h40, 1'b1});
    @(posedge clk); #1;
    chk("ws_beat1", {bus.dat_o[30:0], bus.ack_o}, {31'h41, 1'b1});
    bus.stb_i = 1'b0;
    @(posedge clk); #1;
    chk("ws_hold", {29'd0, bus.state_o, bus.ack_o}, {29'd0, 2'b10, 1'b0});
    bus.stb_i = 1'b1;
    @(posedge clk); #1;
    chk("ws_resume", {bus.dat_o[30:0], bus.ack_o}, {31'h41, 1'b1});
    @(posedge clk); #1;
    chk("ws_beat2", {bus.dat_o[30:0], bus.ack_o}, {31'h42, 1'b1});

    // Asynchronous reset while ack_o is high mid-burst
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {bus.dat_o[28:0], bus.state_o, bus.ack_o}, 32'd0);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    vecs[13].adr = 5'd4;
    vecs[13].exp_dat = 32'h0;
    classic(vecs[13], "mem_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/wb_burst_slave_mem.md
Name: wb_burst_slave_mem

Overview:
Parametrised Wishbone B4 registered-feedback slave memory for the single-slave system. It replaces the classic-only slave and adds the following:
- full CTI handling: classic, constant-address burst, incrementing burst, end-of-burst;
- BTE linear and wrap-4/8/16 address sequencing;
- byte-lane writes;
- error termination for out-of-range addresses and reserved cycle types.

It sits directly behind the master in wishbone_top and drives ack_i/err_i/data_i back to it.

Parameters:
ADDR_WIDTH, 5, word-address width of adr_i
DATA_WIDTH, 32, data bus width (multiple of 8)
SEL_WIDTH, DATA_WIDTH/8, byte-select width
DEPTH, 24, number of implemented words (1..2**ADDR_WIDTH); addresses >= DEPTH are errors

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
cyc_i  in  1  bus cycle valid
stb_i  in  1  strobe
we_i  in  1  write enable
adr_i  in  ADDR_WIDTH  word address
dat_i  in  DATA_WIDTH  write data
sel_i  in  SEL_WIDTH  byte selects
cti_i  in  3  cycle type identifier
bte_i  in  2  burst type extension
dat_o  out  DATA_WIDTH  registered read data
ack_o  out  1  registered acknowledge
err_o  out  1  registered error
state_o  out  2  FSM state: 00 IDLE, 01 CLASSIC, 10 BURST, 11 ERR

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values: dat_o=0, ack_o=0, err_o=0, state_o=IDLE, internal burst address=0, memory array cleared to 0.
- Beat completion: a beat completes on a rising edge where cyc_i & stb_i & (ack_o | err_o).
- Writes:
  - On a completed write beat, each byte lane k of mem[cur_addr] is updated only where sel_i[k]=1.
  - Errored beats never write.
- Error conditions:
  - address >= DEPTH;
  - cti_i in 011..110.
- IDLE, on cyc_i & stb_i:
  - Error condition -> ERR, err_o=1 next cycle.
  - cti_i=001 or 010 -> BURST. cur_addr<=adr_i, dat_o<=mem[adr_i], ack_o=1 next cycle (one wait state on the first beat).
  - cti_i=000 or 111 -> CLASSIC. dat_o<=mem[adr_i], ack_o=1 next cycle.
- CLASSIC:
  - ack_o high for exactly one cycle, then ack_o<=0 and return to IDLE.
  - This gives one dead cycle minimum between classic transfers.
- BURST:
  - On each completed beat, next address is computed:
    - cti_i=001: address held;
    - bte 00: linear cur+1;
    - bte 01: wrap-4, low 2 bits increment modulo 4;
    - bte 10: wrap-8, low 3 bits;
    - bte 11: wrap-16, low 4 bits;
    - upper address bits are held for all wrap modes.
  - On the same edge: cur_addr<=next and dat_o<=mem[next].
  - ack_o stays 1, giving back-to-back beats.
  - Next address >= DEPTH: ack_o<=0, err_o<=1 for the following beat, go to ERR.
  - Completed beat with cti_i=111 ends the burst: ack_o<=0, go to IDLE.
  - stb_i low while cyc_i high (master wait state): ack_o<=0, stay in BURST, hold cur_addr. When stb_i returns, ack_o<=1 on the next cycle, data still for cur_addr.
  - we_i is constant within a burst; a mid-burst change is illegal and undefined.
- ERR: err_o high exactly one cycle, then err_o<=0 and go to IDLE.
- Output exclusivity: ack_o and err_o are never simultaneously 1.
- cyc_i deasserted in any state: next edge gives ack_o=0, err_o=0, IDLE. Any in-flight beat that had not completed is dropped.
- rst_i mid-operation: outputs take their reset values immediately (asynchronously). The memory is cleared.
- Same-address read/write: read data for a beat is the array value before that beat's write. A constant-address write burst followed by a read returns the last written value.

Optional Feature:
WB_BURST_STATS_EN
- Defined: adds two outputs.
  - beat_cnt_o [7:0]: beats in the last completed burst. It counts from the first burst ack and is latched on the end-of-burst beat.
  - err_cnt_o [7:0]: total err_o pulses, saturating at 255.
  - Both reset to 0.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
1. Classic write adr 0 = 0x0000_1111, cti 000, then classic read adr 0 -> ack_o one cycle after stb, single-cycle pulse; dat_o=0x0000_1111 with ack.
2. Incrementing linear burst write at adr 4, cti 010, bte 00, data 0xA0..0xA3, last beat cti 111 -> acks on 4 consecutive cycles after 1 wait state. Burst read returns 0xA0,0xA1,0xA2,0xA3; state_o returns to 00.
3. Wrap-4 burst read starting adr 6 (memory 4..7 preloaded 0x40..0x43) -> dat_o sequence 0x42,0x43,0x40,0x41.
4. Byte-lane write sel 0010 data 0xAABB_CCDD to a word holding 0x1111_1111 -> readback 0x1111_CC11.
5. Error cases:
   - Classic write adr 20 with DEPTH 24 -> normal ack; write to adr 25 -> err_o one cycle, no ack, memory unchanged.
   - cti 011 -> err_o.
   - Linear burst from adr 22 -> acks for 22 and 23, then err_o on the third beat.
6. Master stb wait state mid-burst -> ack_o drops for that cycle and the burst resumes with the same address. rst_i asserted mid-burst -> ack_o=0, state_o=00 without waiting for a clock edge.
